// File: rtl/fp_add_arbiter_if.sv
// Requester/response/adder bundle for fp_add_arbiter.
// The slave modport is the arbiter side; the master modport is the requesters plus adder side.
interface fp_add_arbiter_if;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp0_sum, rsp1_sum;
  logic [15:0] add_a, add_b, add_sum;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
           rsp0_ready, rsp1_ready, add_sum,
    output req0_ready, req1_ready, rsp0_valid, rsp0_sum, rsp1_valid, rsp1_sum,
           add_a, add_b, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
           rsp0_ready, rsp1_ready, add_sum,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_sum, rsp1_valid, rsp1_sum,
           add_a, add_b, busy
  );
endinterface

// File: rtl/fp_add_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency FP16 adder.
// Each requester has its own response FIFO, and that FIFO's depth caps its outstanding ops.
module fp_add_arbiter_rsp #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_i,
  input  logic                     wr_i,
  input  logic [15:0]              wdata_i,
  input  logic                     rdy_i,
  output logic                     vld_o,
  output logic [15:0]              sum_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] occ_q, occ_d, cnt_q, cnt_d;
  logic          pop;

  assign vld_o = (occ_q != '0);
  assign sum_o = vld_o ? mem_q[rp_q] : '0;
  assign pop   = vld_o & rdy_i;
  assign cnt_o = cnt_q;

  // Simultaneous inc/dec cancel, so occupancy and credit simply hold.
  assign occ_d = occ_q + CW'(wr_i) - CW'(pop);
  assign cnt_d = cnt_q + CW'(issue_i) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_i) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wp_q] <= wdata_i;
  end
endmodule

module fp_add_arbiter #(
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fp_add_arbiter_if.slave    bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]          vld, elig, rdy, rsp_rdy, rsp_vld, wr;
  logic [1:0][15:0]    op_a, op_b, rsp_sum;
  logic [1:0][CW-1:0]  cnt;
  logic                gnt_vld, gnt_id, hs, ptr_q, ptr_d;
  logic [15:0]         add_a_q, add_a_d, add_b_q, add_b_d;
  logic [LAT:0]        tv_q, ti_q;

  assign vld     = {bus.req1_valid, bus.req0_valid};
  assign op_a    = {bus.req1_a, bus.req0_a};
  assign op_b    = {bus.req1_b, bus.req0_b};
  assign rsp_rdy = {bus.rsp1_ready, bus.rsp0_ready};

  for (genvar n = 0; n < 2; n++) begin : g_elig
    assign elig[n] = vld[n] && (cnt[n] < CW'(DEPTH));
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (elig == 2'b11) begin
      gnt_vld = 1'b1;
      gnt_id  = ptr_q;
    end else if (elig[0]) begin
      gnt_vld = 1'b1;
    end else if (elig[1]) begin
      gnt_vld = 1'b1;
      gnt_id  = 1'b1;
    end
  end

  // Ready is gated by reset so nothing is offered while the block is held.
  assign rdy     = {2{rst_n & gnt_vld}} & {gnt_id, ~gnt_id};
  assign hs      = |rdy;
  assign ptr_d   = hs ? ~gnt_id : ptr_q;
  assign add_a_d = hs ? op_a[gnt_id] : add_a_q;
  assign add_b_d = hs ? op_b[gnt_id] : add_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= 1'b0;
      add_a_q <= '0;
      add_b_q <= '0;
      tv_q    <= '0;
      ti_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      tv_q    <= {tv_q[LAT-1:0], hs};
      ti_q    <= {ti_q[LAT-1:0], gnt_id};
    end
  end

  // The last tag stage lines up with add_sum for the op issued LAT+1 edges ago.
  assign wr = {tv_q[LAT] & ti_q[LAT], tv_q[LAT] & ~ti_q[LAT]};

  for (genvar n = 0; n < 2; n++) begin : g_rsp
    fp_add_arbiter_rsp #(.DEPTH(DEPTH)) u_rsp (
      .clk     (clk),
      .rst_n   (rst_n),
      .issue_i (rdy[n]),
      .wr_i    (wr[n]),
      .wdata_i (bus.add_sum),
      .rdy_i   (rsp_rdy[n]),
      .vld_o   (rsp_vld[n]),
      .sum_o   (rsp_sum[n]),
      .cnt_o   (cnt[n])
    );
  end

  assign bus.req0_ready = rdy[0];
  assign bus.req1_ready = rdy[1];
  assign bus.rsp0_valid = rsp_vld[0];
  assign bus.rsp1_valid = rsp_vld[1];
  assign bus.rsp0_sum   = rsp_sum[0];
  assign bus.rsp1_sum   = rsp_sum[1];
  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.busy       = (|tv_q) | (|rsp_vld);
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: table-driven single ops plus hand sequences for arbitration,
// back-pressure, ordering, same-cycle events and mid-flight reset, with a scoreboard.
module tb_fp_add_arbiter;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic clk, rst_n;
  fp_add_arbiter_if bus ();

  fp_add_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model adder: exact only for same-sign, equal-exponent normal operands.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [11:0] m;
    m = 12'({1'b1, a[9:0]}) + 12'({1'b1, b[9:0]});
    return {a[15], a[14:10] + 5'd1, m[10:1]};
  endfunction

  logic [15:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= fp16_add(bus.add_a, bus.add_b);
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign bus.add_sum = apipe[LAT-1];

  int nchk = 0, nerr = 0;
  int hs_cnt [2];
  int glog [$];
  logic [15:0] sb0 [$], sb1 [$], r1log [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: handshake and pop are sampled mid-cycle, where inputs are stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb0.delete();
      sb1.delete();
    end else begin
      if (bus.req0_valid && bus.req0_ready) begin
        sb0.push_back(fp16_add(bus.req0_a, bus.req0_b)); hs_cnt[0]++; glog.push_back(0);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sb1.push_back(fp16_add(bus.req1_a, bus.req1_b)); hs_cnt[1]++; glog.push_back(1);
      end
      if (bus.rsp0_valid && bus.rsp0_ready) begin
        if (sb0.size() == 0) begin
          nchk++; nerr++; $display("FAIL rsp0_unexpected: got %0h expected none", bus.rsp0_sum);
        end else check("rsp0_sb", bus.rsp0_sum, sb0.pop_front());
      end
      if (bus.rsp1_valid && bus.rsp1_ready) begin
        r1log.push_back(bus.rsp1_sum);
        if (sb1.size() == 0) begin
          nchk++; nerr++; $display("FAIL rsp1_unexpected: got %0h expected none", bus.rsp1_sum);
        end else check("rsp1_sb", bus.rsp1_sum, sb1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [15:0] a, input logic [15:0] b);
    if (n == 0) begin bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; end
    else        begin bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; end
  endtask

  function automatic logic get_rdy(input int n);
    return (n == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  task automatic issue(input int n, input logic [15:0] a, input logic [15:0] b);
    bit got = 0;
    set_req(n, 1'b1, a, b);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (get_rdy(n)) begin got = 1; break; end
    end
    if (got) begin @(posedge clk); #1; end
    else begin nchk++; nerr++; $display("FAIL issue_timeout: got no ready expected ready on req%0d", n); end
    set_req(n, 1'b0, a, b);
  endtask

  task automatic wait_rsp(input int n, output logic [15:0] sum, output bit found);
    found = 0; sum = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (n == 0 && bus.rsp0_valid) begin found = 1; sum = bus.rsp0_sum; break; end
      if (n == 1 && bus.rsp1_valid) begin found = 1; sum = bus.rsp1_sum; break; end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!bus.busy) break;
      tick();
    end
    check("drain_idle", bus.busy, 1'b0);
  endtask

  typedef struct {
    int          n;
    logic [15:0] a, b, exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [15:0] s;
    bit          f;
    int          lat, stale, h0;

    vecs[0] = '{0, 16'h3C00, 16'h3C00, 16'h4000};
    vecs[1] = '{1, 16'h4000, 16'h4000, 16'h4400};
    vecs[2] = '{0, 16'h3E00, 16'h3E00, 16'h4200};
    vecs[3] = '{1, 16'h3C00, 16'h3E00, 16'h4100};
    vecs[4] = '{0, 16'hBC00, 16'hBC00, 16'hC000};
    vecs[5] = '{1, 16'h4900, 16'h4800, 16'h4C80};

    rst_n = 1'b0;
    set_req(0, 1'b1, 16'h3C00, 16'h3C00);
    set_req(1, 1'b0, 16'h0000, 16'h0000);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    hs_cnt[0] = 0; hs_cnt[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req0_ready", bus.req0_ready, 1'b0);
    check("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
    check("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
    check("rst_rsp0_sum",   bus.rsp0_sum,   16'h0000);
    check("rst_add_a",      bus.add_a,      16'h0000);
    check("rst_busy",       bus.busy,       1'b0);

    // Single op latency and busy behaviour.
    rst_n = 1'b1;
    @(negedge clk);
    check("first_grant_req0", bus.req0_ready, 1'b1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h3C00, 16'h3C00);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      tick(); lat++;
      if (bus.rsp0_valid) break;
    end
    check("single_latency", lat, LAT + 2);
    check("single_sum", bus.rsp0_sum, 16'h4000);
    check("single_busy", bus.busy, 1'b1);
    bus.rsp0_ready = 1'b1;
    tick();
    check("single_busy_after_pop", bus.busy, 1'b0);

    // Table-driven ops on alternating requesters.
    bus.rsp1_ready = 1'b1;
    foreach (vecs[k]) begin
      issue(vecs[k].n, vecs[k].a, vecs[k].b);
      wait_rsp(vecs[k].n, s, f);
      check($sformatf("vec%0d_found", k), f, 1'b1);
      check($sformatf("vec%0d_sum", k), s, vecs[k].exp);
    end
    wait_idle();

    // Contention right after a reset: grants alternate starting at 0.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    glog.delete();
    set_req(0, 1'b1, 16'h3C00, 16'h3C00);
    set_req(1, 1'b1, 16'h4000, 16'h4000);
    repeat (8) tick();
    set_req(0, 1'b0, 16'h0, 16'h0);
    set_req(1, 1'b0, 16'h0, 16'h0);
    check("cont_grants", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      check($sformatf("cont_grant%0d", i), glog[i], i % 2);
    wait_idle();

    // Back-pressure on requester 0.
    bus.rsp0_ready = 1'b0;
    hs_cnt[0] = 0;
    set_req(0, 1'b1, 16'h3E00, 16'h3E00);
    repeat (12) tick();
    check("bp_hs_count", hs_cnt[0], DEPTH);
    @(negedge clk);
    check("bp_req0_blocked", bus.req0_ready, 1'b0);
    set_req(1, 1'b1, 16'h3C00, 16'h3C00);
    @(negedge clk);
    check("bp_req1_served", bus.req1_ready, 1'b1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 16'h0, 16'h0);
    wait_rsp(0, s, f);
    check("bp_rsp0_present", f, 1'b1);
    h0 = hs_cnt[0];
    bus.rsp0_ready = 1'b1; tick(); bus.rsp0_ready = 1'b0;
    repeat (10) tick();
    check("bp_one_more", hs_cnt[0], h0 + 1);
    set_req(0, 1'b0, 16'h0, 16'h0);
    bus.rsp0_ready = 1'b1;
    wait_idle();

    // Ordering with FIFO wrap on requester 1.
    r1log.delete();
    for (int i = 0; i < 8; i++) begin
      s = 16'h3C00 + 16'(i * 16'h0080);
      issue(1, s, s);
    end
    wait_idle();
    check("ord_count", r1log.size(), 8);
    for (int i = 0; i < 8 && i < r1log.size(); i++)
      check($sformatf("ord%0d", i), r1log[i], 16'h4000 + 16'(i * 16'h0080));

    // Issue, result write and pop on requester 0 in one cycle.
    bus.rsp0_ready = 1'b0;
    set_req(0, 1'b1, 16'h3C00, 16'h3C00);
    tick();
    set_req(0, 1'b1, 16'h4000, 16'h4000);
    tick();
    set_req(0, 1'b0, 16'h0, 16'h0);
    repeat (4) tick();
    check("simul_pre_valid", bus.rsp0_valid, 1'b1);
    check("simul_pre_head",  bus.rsp0_sum, 16'h4000);
    check("simul_pre_cnt",   dut.g_rsp[0].u_rsp.cnt_q, 2);
    check("simul_pre_occ",   dut.g_rsp[0].u_rsp.occ_q, 1);
    set_req(0, 1'b1, 16'h3E00, 16'h3E00);
    bus.rsp0_ready = 1'b1;
    tick();
    set_req(0, 1'b0, 16'h0, 16'h0);
    bus.rsp0_ready = 1'b0;
    check("simul_post_cnt",  dut.g_rsp[0].u_rsp.cnt_q, 2);
    check("simul_post_occ",  dut.g_rsp[0].u_rsp.occ_q, 1);
    check("simul_post_head", bus.rsp0_sum, 16'h4400);
    bus.rsp0_ready = 1'b1;
    wait_idle();

    // Reset with three ops in flight.
    issue(0, 16'h3C00, 16'h3C00);
    issue(1, 16'h4000, 16'h4000);
    issue(0, 16'h3E00, 16'h3E00);
    check("mid_busy_before", bus.busy, 1'b1);
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.rsp0_valid || bus.rsp1_valid) stale++;
    end
    check("mid_no_stale", stale, 0);
    check("mid_busy", bus.busy, 1'b0);
    set_req(0, 1'b1, 16'h3C00, 16'h3C00);
    set_req(1, 1'b1, 16'h4000, 16'h4000);
    @(negedge clk);
    check("mid_grant_req0", bus.req0_ready, 1'b1);
    check("mid_grant_not_req1", bus.req1_ready, 1'b0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 16'h0, 16'h0);
    set_req(1, 1'b0, 16'h0, 16'h0);
    wait_idle();

    check("sb0_empty", sb0.size(), 0);
    check("sb1_empty", sb1.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
